// File: rtl/hazard_scoreboard.sv
// Shadow of the EX/MEM/WB destinations for the instruction in ID: drives the
// forwarding-unit destination fields and raises the ID stall request.
module hazard_scoreboard #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   forwarding_en,
    input  logic                   freeze,
    input  logic                   flush,
    input  logic                   id_valid,
    input  logic [3:0]             id_src1,
    input  logic [3:0]             id_src2,
    input  logic                   id_two_src,
    input  logic                   id_wb_en,
    input  logic                   id_mem_read,
    input  logic [3:0]             id_dest,
    output logic                   hazard,
    output logic [3:0]             exe_dest,
    output logic [3:0]             mem_dest,
    output logic [3:0]             wb_dest,
    output logic                   exe_wb_en,
    output logic                   mem_wb_en,
    output logic                   wb_wb_en,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [STALL_CNT_W-1:0] CNT_MAX = {STALL_CNT_W{1'b1}};

    // Index 0 = EX, 1 = MEM, 2 = WB. Only EX needs the load flag.
    logic [2:0]       valid_q, valid_d;
    logic [2:0]       wb_en_q, wb_en_d;
    logic [3:0]       dest_q [3];
    logic [3:0]       dest_d [3];
    logic             exe_mem_read_q, exe_mem_read_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    logic [2:0]       match;
    logic [2:0]       live_wb;

    for (genvar gi = 0; gi < 3; gi++) begin : g_match
        assign live_wb[gi] = valid_q[gi] && wb_en_q[gi];
        assign match[gi]   = live_wb[gi] &&
                             ((id_src1 == dest_q[gi]) ||
                              (id_two_src && (id_src2 == dest_q[gi])));
    end

    // W never stalls: the register file writes it in the first half-cycle.
    always_comb begin
        hazard = 1'b0;
        if (id_valid && !flush) begin
            if (forwarding_en) begin
                hazard = match[0] && exe_mem_read_q;
            end else begin
                hazard = match[0] || match[1];
            end
        end
    end

    always_comb begin
        valid_d        = valid_q;
        wb_en_d        = wb_en_q;
        dest_d         = dest_q;
        exe_mem_read_d = exe_mem_read_q;
        stall_d        = stall_q;
        if (!freeze) begin
            valid_d[2]     = valid_q[1];
            wb_en_d[2]     = wb_en_q[1];
            dest_d[2]      = dest_q[1];
            valid_d[1]     = valid_q[0];
            wb_en_d[1]     = wb_en_q[0];
            dest_d[1]      = dest_q[0];
            valid_d[0]     = id_valid && !hazard && !flush;
            wb_en_d[0]     = id_wb_en;
            dest_d[0]      = id_dest;
            exe_mem_read_d = id_mem_read;
            if (hazard && (stall_q != CNT_MAX)) begin
                stall_d = stall_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q        <= '0;
            wb_en_q        <= '0;
            exe_mem_read_q <= 1'b0;
            stall_q        <= '0;
            for (int i = 0; i < 3; i++) begin
                dest_q[i] <= '0;
            end
        end else begin
            valid_q        <= valid_d;
            wb_en_q        <= wb_en_d;
            exe_mem_read_q <= exe_mem_read_d;
            stall_q        <= stall_d;
            for (int i = 0; i < 3; i++) begin
                dest_q[i] <= dest_d[i];
            end
        end
    end

    assign exe_dest     = dest_q[0];
    assign mem_dest     = dest_q[1];
    assign wb_dest      = dest_q[2];
    assign exe_wb_en    = live_wb[0];
    assign mem_wb_en    = live_wb[1];
    assign wb_wb_en     = live_wb[2];
    assign stall_cycles = stall_q;

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Tracks every instruction that leaves ID in a three-entry shadow of the EX, MEM and WB stages. From that shadow it drives the destination and write-enable fields consumed by the forwarding unit, and it raises `hazard` when the instruction in ID must stall. It sits beside the ID stage, on the producer side of the forwarding path, and it replaces the ad-hoc comparators in the top-level core.

## Interface
- `STALL_CNT_W`, default 16: width of the saturating stall-cycle counter.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `forwarding_en`  in  1  1 means forwarding is active, so only load-use hazards stall.
- `freeze`  in  1  memory-wait freeze; the whole pipeline holds.
- `flush`  in  1  branch taken; the ID instruction is discarded.
- `id_valid`  in  1  the ID stage holds a real instruction.
- `id_src1`  in  4  first source register.
- `id_src2`  in  4  second source register.
- `id_two_src`  in  1  `id_src2` is actually read.
- `id_wb_en`  in  1  the ID instruction writes the register file.
- `id_mem_read`  in  1  the ID instruction is a load.
- `id_dest`  in  4  destination of the ID instruction.
- `hazard`  out  1  stall IF/ID and insert a bubble into EX.
- `exe_dest`, `mem_dest`, `wb_dest`  out  4 each  shadow destinations.
- `exe_wb_en`, `mem_wb_en`, `wb_wb_en`  out  1 each  shadow write enables, qualified by the entry's valid bit.
- `stall_cycles`  out  `STALL_CNT_W`  count of cycles where `hazard`=1 and `freeze`=0; saturates.

## Operation
- Each shadow entry holds {valid, wb_en, mem_read, dest}. Entries: E (EX), M (MEM), W (WB).
- Match rules:
  - src1 match: `id_src1` == entry.dest.
  - src2 match: `id_two_src` && `id_src2` == entry.dest.
  - An entry only matches when entry.valid && entry.wb_en.
- `hazard` is combinational. It is 1 only when `id_valid` && !`flush` and one of these holds:
  - `forwarding_en`=1: E matches and E.mem_read=1 (load-use).
  - `forwarding_en`=0: E or M matches. W never causes a stall, because the register file writes W in the first half-cycle.
- Shift on each rising edge when `freeze`=0:
  - W←M and M←E.
  - E←{valid=`id_valid` && !`hazard` && !`flush`, `id_wb_en`, `id_mem_read`, `id_dest`}.
  - A hazard or flush therefore loads a bubble (valid=0) into E.
- `freeze`=1: all entries hold and `stall_cycles` holds. `hazard` is still evaluated.
- When valid=0, the `*_wb_en` outputs are 0. The `*_dest` outputs always show the stored field.
- `stall_cycles` increments when `hazard`=1 and `freeze`=0, and sticks at all-ones.

## Timing
- Reset (`rst`=0 at an edge) clears all entries to zero. After that edge:
  - every `*_wb_en`=0 and every `*_dest`=0;
  - `stall_cycles`=0;
  - `hazard`=0.
- Reset takes priority over `freeze` and `flush`. A reset mid-stall drops any pending hazard on the next cycle.
- Latency: an ID instruction accepted at edge N is in E after N, in M after N+1 and in W after N+2.
- Stall lengths:
  - Load-use with forwarding: `hazard` lasts exactly 1 cycle when no freeze occurs.
  - Without forwarding, a dependence on E stalls 2 cycles; a dependence on M stalls 1 cycle.
- `flush` and `hazard` in the same cycle: `hazard` is forced to 0 and a bubble enters E.
- A source equal to a destination in both E and M counts as a single stall condition; the stall lasts until neither entry matches.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with `id_valid`=1 → all outputs 0 and `stall_cycles`=0.
- Load-use:
  - Cycle 0: `forwarding_en`=1, issue a load with `id_dest`=3.
  - Cycle 1: ID reads `id_src1`=3.
  - Expected: `hazard`=1 for exactly one cycle, then 0. `exe_wb_en` is 0 for the bubble cycle, and `mem_dest`=3 / `mem_wb_en`=1 line up with the consumer reaching EX. `stall_cycles`=1.
- No forwarding:
  - Cycle 0: issue an ADD with `id_dest`=5.
  - Next instruction has `id_src2`=5 and `id_two_src`=1, with `forwarding_en`=0.
  - Expected: `hazard`=1 for 2 cycles. With `id_two_src`=0 instead → `hazard` never asserts.
- Freeze during stall:
  - Assert `freeze` for 3 cycles in the middle of a load-use stall.
  - Expected: entries and `stall_cycles` hold; `hazard` stays 1; the stall resolves 1 cycle after `freeze` drops.
- Flush: `flush`=1 together with a matching load in E → `hazard`=0 and E.valid=0 after the edge.
- Saturation: with `STALL_CNT_W`=4, run 20 stall cycles → `stall_cycles`=15.
